dcmac_0_axis_pkt_cnt_ext: RTL
=============================

Name: dcmac_0_axis_pkt_cnt_ext

Overview:
- Downstream extension stage for the DCMAC AXIS per-channel packet/byte counter.
- Consumes the time-slotted carry stream (channel id plus pkt/byte carry bits) that the 32-bit counter emits every cycle, and keeps the upper HI_W bits per channel.
- On a software clear edge it snapshots the upper halves into output registers, so software can assemble {hi, lo} pkt/byte counts per channel.

Parameters:
- NUM_CH, 6: number of channels; valid ids are 0..NUM_CH-1.
- HI_W, 32: width of each upper counter segment.
- REGISTER_INPUT, 1: 1 = register the carry inputs (id, pkt carry, byte carry) one cycle before use; 0 = use them directly.

Ports:
- clk, input, 1: single clock.
- rst, input, 1: asynchronous, active-high reset.
- i_clear_counters, input, NUM_CH: per-channel level clear request; the rising edge is what counts.
- i_carry_id_m1, input, 3: channel id of this cycle's carry slot; ids >= NUM_CH are ignored.
- i_pkt_cnt_carry, input, 1: packet-count carry out of the low 32 bits for i_carry_id_m1.
- i_byte_cnt_carry, input, 1: byte-count carry out of the low 32 bits for i_carry_id_m1.
- o_pkt_cnt_hi, output, NUM_CH x HI_W: snapshotted upper packet count per channel.
- o_byte_cnt_hi, output, NUM_CH x HI_W: snapshotted upper byte count per channel.
- o_pkt_hi_ovf, output, NUM_CH: snapshotted overflow flag, set if the upper packet segment wrapped.
- o_byte_hi_ovf, output, NUM_CH: snapshotted overflow flag, set if the upper byte segment wrapped.
- o_clear_done, output, NUM_CH: one-cycle pulse per channel when its snapshot is taken.

Behaviour:
- Reset (async, rst=1):
  - All internal hi counters, sticky overflow bits, pending flags and clear edge-detect registers go to 0.
  - All outputs go to 0.
  - A reset asserted mid-operation discards any pending clears.
- Input stage:
  - With REGISTER_INPUT=1, id and carries are registered once; call the used values id_s, pc_s, bc_s.
  - With REGISTER_INPUT=0, id_s/pc_s/bc_s are the raw inputs.
- Counting, in the cycle id_s < NUM_CH:
  - hi_pkt[id_s] <= hi_pkt[id_s] + pc_s, modulo 2^HI_W.
  - hi_byte[id_s] <= hi_byte[id_s] + bc_s, modulo 2^HI_W.
  - Wrap (all-ones + 1) sets sticky ovf_pkt[id_s] or ovf_byte[id_s].
  - Latency from carry input to internal counter update: 1 cycle (REGISTER_INPUT=0) or 2 cycles (REGISTER_INPUT=1).
  - An id_s >= NUM_CH is a no-op.
- Clear edge detect:
  - clr_q <= i_clear_counters; clr_qq <= clr_q.
  - edge[i] = clr_q[i] & ~clr_qq[i].
  - edge[i] sets pending[i] on the next cycle.
- Snapshot, when pending[id_s]=1 in a carry slot for id_s (state IDLE -> PENDING -> SNAP per channel; SNAP lasts one cycle, then IDLE):
  - o_pkt_cnt_hi[id_s] <= hi_pkt[id_s] and o_byte_cnt_hi[id_s] <= hi_byte[id_s]; these are the values before this slot's carry.
  - o_*_hi_ovf[id_s] <= ovf_*[id_s].
  - hi_pkt <= pc_s and hi_byte <= bc_s (the carry starts the new epoch); ovf bits <= 0.
  - pending[id_s] <= 0; o_clear_done[id_s] pulses 1 cycle later, aligned with the updated outputs.
- Simultaneous new edge and consume on the same channel: pending stays 1 (set wins), giving a second snapshot on the next slot of that channel.
- Repeated edges while already PENDING collapse into one snapshot.
- Outputs hold their values between snapshots; o_clear_done is 0 otherwise.
- Clears for different channels are independent; all NUM_CH can be pending at once.

Decomposition:
- Shared package dcmac_0_cnt_pkg:
  - NUM_CH_DEF=6, CNT_LO_W=32, CNT_HI_W=32, CH_ID_W=3.
  - Typedef cnt_hi_arr_t (NUM_CH x HI_W).
  - Typedef ch_mask_t (NUM_CH).
- Sub-module dcmac_0_cnt_hi_slice: one per-channel slice holding the hi pkt/byte counters, sticky ovf and pending flag, instantiated with a generate loop.
- Top level holds the input stage, edge detect and id decode.

Test Plan:
- Reset then 10 pkt carries on id 2, then clear edge on ch2 -> within 3 cycles of the next id-2 slot, o_pkt_cnt_hi[2]=10, o_byte_cnt_hi[2]=0, o_clear_done[2] pulses once; other channels stay 0.
- Preload hi_byte[4]=0xFFFF_FFFF via carries (force), one byte carry, clear ch4 -> o_byte_cnt_hi[4]=0, o_byte_hi_ovf[4]=1.
- Clear ch1 where the consume slot also carries pc_s=1 -> snapshot excludes that carry; the next clear with no further carries gives o_pkt_cnt_hi[1]=1.
- i_clear_counters held high 20 cycles on ch0 -> exactly one o_clear_done[0] pulse; toggling 0-1-0-1 fast -> at most two snapshots.
- Carries on ids 6 and 7 -> no counter changes. Async rst asserted while pending[3]=1 -> outputs 0, no later o_clear_done[3].
- Round-robin ids 0..5 with random carries over 10k cycles, clear all channels -> o_*_cnt_hi matches the scoreboard count per channel, in both REGISTER_INPUT settings.

Source files
------------

// File: rtl/dcmac_0_cnt_pkg.sv
// Shared types and constants for the DCMAC AXIS per-channel counter extension.
package dcmac_0_cnt_pkg;

    localparam int unsigned NUM_CH_DEF = 6;
    localparam int unsigned CNT_LO_W   = 32;
    localparam int unsigned CNT_HI_W   = 32;
    localparam int unsigned CH_ID_W    = 3;

    // Upper count segment for every channel, packed channel-major.
    typedef logic [NUM_CH_DEF-1:0][CNT_HI_W-1:0] cnt_hi_arr_t;

    // One bit per channel.
    typedef logic [NUM_CH_DEF-1:0] ch_mask_t;

    // Per-channel clear/snapshot handshake state.
    typedef enum logic [1:0] {
        CLR_IDLE    = 2'd0,
        CLR_PENDING = 2'd1,
        CLR_SNAP    = 2'd2
    } clr_state_e;

endpackage

// File: rtl/dcmac_0_cnt_hi_slice.sv
// One channel of the counter extension: upper pkt/byte segments, sticky wrap
// flags, clear-pending state and the software-visible snapshot registers.
module dcmac_0_cnt_hi_slice
    import dcmac_0_cnt_pkg::*;
#(
    parameter int unsigned HI_W = CNT_HI_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            slot_i,
    input  logic            pkt_carry_i,
    input  logic            byte_carry_i,
    input  logic            clr_edge_i,
    output logic [HI_W-1:0] pkt_hi_o,
    output logic [HI_W-1:0] byte_hi_o,
    output logic            pkt_ovf_o,
    output logic            byte_ovf_o,
    output logic            clear_done_o
);

    clr_state_e      state_q, state_d;
    logic [HI_W-1:0] pkt_hi_q, pkt_hi_d;
    logic [HI_W-1:0] byte_hi_q, byte_hi_d;
    logic            pkt_ovf_q, pkt_ovf_d;
    logic            byte_ovf_q, byte_ovf_d;
    logic [HI_W-1:0] pkt_snap_q, pkt_snap_d;
    logic [HI_W-1:0] byte_snap_q, byte_snap_d;
    logic            pkt_ovf_snap_q, pkt_ovf_snap_d;
    logic            byte_ovf_snap_q, byte_ovf_snap_d;
    logic            done_q, done_d;

    logic            consume_c;
    logic [HI_W-1:0] pkt_sum_c;
    logic [HI_W-1:0] byte_sum_c;
    logic            pkt_wrap_c;
    logic            byte_wrap_c;

    // Carry arithmetic for the live segments; a wrap is all-ones plus a carry.
    always_comb begin
        pkt_sum_c   = pkt_hi_q + HI_W'(pkt_carry_i);
        byte_sum_c  = byte_hi_q + HI_W'(byte_carry_i);
        pkt_wrap_c  = pkt_carry_i & (&pkt_hi_q);
        byte_wrap_c = byte_carry_i & (&byte_hi_q);
    end

    // Next state: clear handshake, counting and snapshot on the channel's slot.
    always_comb begin
        state_d         = state_q;
        pkt_hi_d        = pkt_hi_q;
        byte_hi_d       = byte_hi_q;
        pkt_ovf_d       = pkt_ovf_q;
        byte_ovf_d      = byte_ovf_q;
        pkt_snap_d      = pkt_snap_q;
        byte_snap_d     = byte_snap_q;
        pkt_ovf_snap_d  = pkt_ovf_snap_q;
        byte_ovf_snap_d = byte_ovf_snap_q;
        done_d          = 1'b0;
        consume_c       = 1'b0;

        case (state_q)
            CLR_IDLE: begin
                if (clr_edge_i) begin
                    state_d = CLR_PENDING;
                end
            end
            CLR_PENDING: begin
                if (slot_i) begin
                    consume_c = 1'b1;
                    // A fresh edge in the consuming cycle re-arms another snapshot.
                    state_d   = clr_edge_i ? CLR_PENDING : CLR_SNAP;
                end
            end
            CLR_SNAP: begin
                state_d = clr_edge_i ? CLR_PENDING : CLR_IDLE;
            end
            default: begin
                state_d = CLR_IDLE;
            end
        endcase

        if (slot_i) begin
            if (consume_c) begin
                // Snapshot excludes this slot's carry, which opens the new epoch.
                pkt_snap_d      = pkt_hi_q;
                byte_snap_d     = byte_hi_q;
                pkt_ovf_snap_d  = pkt_ovf_q;
                byte_ovf_snap_d = byte_ovf_q;
                pkt_hi_d        = HI_W'(pkt_carry_i);
                byte_hi_d       = HI_W'(byte_carry_i);
                pkt_ovf_d       = 1'b0;
                byte_ovf_d      = 1'b0;
                done_d          = 1'b1;
            end else begin
                pkt_hi_d   = pkt_sum_c;
                byte_hi_d  = byte_sum_c;
                pkt_ovf_d  = pkt_ovf_q | pkt_wrap_c;
                byte_ovf_d = byte_ovf_q | byte_wrap_c;
            end
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= CLR_IDLE;
            pkt_hi_q        <= '0;
            byte_hi_q       <= '0;
            pkt_ovf_q       <= 1'b0;
            byte_ovf_q      <= 1'b0;
            pkt_snap_q      <= '0;
            byte_snap_q     <= '0;
            pkt_ovf_snap_q  <= 1'b0;
            byte_ovf_snap_q <= 1'b0;
            done_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pkt_hi_q        <= pkt_hi_d;
            byte_hi_q       <= byte_hi_d;
            pkt_ovf_q       <= pkt_ovf_d;
            byte_ovf_q      <= byte_ovf_d;
            pkt_snap_q      <= pkt_snap_d;
            byte_snap_q     <= byte_snap_d;
            pkt_ovf_snap_q  <= pkt_ovf_snap_d;
            byte_ovf_snap_q <= byte_ovf_snap_d;
            done_q          <= done_d;
        end
    end

    assign pkt_hi_o     = pkt_snap_q;
    assign byte_hi_o    = byte_snap_q;
    assign pkt_ovf_o    = pkt_ovf_snap_q;
    assign byte_ovf_o   = byte_ovf_snap_q;
    assign clear_done_o = done_q;

endmodule

// File: rtl/dcmac_0_axis_pkt_cnt_ext.sv
// Upper-half extension of the DCMAC AXIS per-channel packet/byte counters.
// Consumes the time-slotted carry stream and snapshots per channel on clear.
module dcmac_0_axis_pkt_cnt_ext
    import dcmac_0_cnt_pkg::*;
#(
    parameter int unsigned NUM_CH         = NUM_CH_DEF,
    parameter int unsigned HI_W           = CNT_HI_W,
    parameter int unsigned REGISTER_INPUT = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             i_clear_counters,
    input  logic [CH_ID_W-1:0]            i_carry_id_m1,
    input  logic                          i_pkt_cnt_carry,
    input  logic                          i_byte_cnt_carry,
    output logic [NUM_CH-1:0][HI_W-1:0]   o_pkt_cnt_hi,
    output logic [NUM_CH-1:0][HI_W-1:0]   o_byte_cnt_hi,
    output logic [NUM_CH-1:0]             o_pkt_hi_ovf,
    output logic [NUM_CH-1:0]             o_byte_hi_ovf,
    output logic [NUM_CH-1:0]             o_clear_done
);

    logic [CH_ID_W-1:0] id_s;
    logic               pc_s;
    logic               bc_s;
    logic [NUM_CH-1:0]  clr_q;
    logic [NUM_CH-1:0]  clr_qq;
    logic [NUM_CH-1:0]  clr_edge_c;
    logic [NUM_CH-1:0]  slot_c;

    if (REGISTER_INPUT != 0) begin : g_in_reg
        logic [CH_ID_W-1:0] id_q;
        logic               pc_q;
        logic               bc_q;

        // Retime the carry slot once before it is decoded.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                id_q <= '0;
                pc_q <= 1'b0;
                bc_q <= 1'b0;
            end else begin
                id_q <= i_carry_id_m1;
                pc_q <= i_pkt_cnt_carry;
                bc_q <= i_byte_cnt_carry;
            end
        end

        assign id_s = id_q;
        assign pc_s = pc_q;
        assign bc_s = bc_q;
    end else begin : g_in_raw
        assign id_s = i_carry_id_m1;
        assign pc_s = i_pkt_cnt_carry;
        assign bc_s = i_byte_cnt_carry;
    end

    // Two-stage sampling of the clear levels for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_q  <= '0;
            clr_qq <= '0;
        end else begin
            clr_q  <= i_clear_counters;
            clr_qq <= clr_q;
        end
    end

    assign clr_edge_c = clr_q & ~clr_qq;

    // One-hot slot decode; ids at or above NUM_CH select no channel.
    always_comb begin
        slot_c = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            slot_c[i] = (id_s == CH_ID_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dcmac_0_cnt_hi_slice #(
            .HI_W (HI_W)
        ) u_slice (
            .clk          (clk),
            .rst          (rst),
            .slot_i       (slot_c[g]),
            .pkt_carry_i  (pc_s),
            .byte_carry_i (bc_s),
            .clr_edge_i   (clr_edge_c[g]),
            .pkt_hi_o     (o_pkt_cnt_hi[g]),
            .byte_hi_o    (o_byte_cnt_hi[g]),
            .pkt_ovf_o    (o_pkt_hi_ovf[g]),
            .byte_ovf_o   (o_byte_hi_ovf[g]),
            .clear_done_o (o_clear_done[g])
        );
    end

endmodule
